// File: rtl/dds_key_ctrl.sv
// dds_key_ctrl: turns debounced key press/release pulses into DDS controls.
// The step key raises Fword (short press = one step, long press = one step
// then auto-repeat); the mode key cycles Wave_Sel on a short press and
// reloads the defaults on a long press.
// Optional build macro DDS_KEY_DOWN_EN adds a down-step key (Dn_P_Flag /
// Dn_R_Flag) that lowers Fword with the same short/long/repeat behaviour.
//
// Handshake: all *_P_Flag / *_R_Flag inputs are single-cycle pulses with no
// back-pressure; Fword_Update is a single-cycle pulse on the cycle Fword
// takes a new value. A release exactly on the long-press threshold cycle is
// treated as a release (no step, no reload).

// Press classifier for a stepping key: IDLE -> HELD -> REPEAT.
// Step is a combinational request, registered by the parent one cycle later.
module key_step_fsm #(
  parameter int unsigned CNT_W      = 24,
  parameter logic [CNT_W-1:0] LONG_CNT   = 24'd5_000_000,
  parameter logic [CNT_W-1:0] REPEAT_CNT = 24'd1_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       P_Flag,
  input  logic       R_Flag,
  output logic       Step,
  output logic [1:0] State
);
  typedef enum logic [1:0] {K_IDLE = 2'd0, K_HELD = 2'd1, K_REPEAT = 2'd2} key_state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CNT - 1'b1;
  localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_CNT - 1'b1;

  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  assign State = state;

  // Step request: short release, long threshold, or repeat period elapsed.
  always_comb begin
    Step = 1'b0;
    case (state)
      K_HELD:   Step = R_Flag ? (cnt < LONG_LAST) : (cnt == LONG_LAST);
      K_REPEAT: Step = !R_Flag && (cnt == REP_LAST);
      default:  Step = 1'b0;
    endcase
  end

  // Press state and hold/repeat counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= K_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        K_IDLE: begin
          if (P_Flag) begin
            state <= K_HELD;
            cnt   <= '0;
          end
        end
        K_HELD: begin
          if (R_Flag) begin
            state <= K_IDLE;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state <= K_REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        K_REPEAT: begin
          if (R_Flag) begin
            state <= K_IDLE;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= K_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

module dds_key_ctrl #(
  parameter int unsigned CNT_W         = 24,
  parameter logic [CNT_W-1:0] LONG_CNT      = 24'd5_000_000,
  parameter logic [CNT_W-1:0] REPEAT_CNT    = 24'd1_000_000,
  parameter logic [31:0]      FWORD_DEFAULT = 32'd85_899,
  parameter logic [31:0]      FWORD_STEP    = 32'd85_899,
  parameter logic [31:0]      FWORD_MIN     = 32'd85_899,
  parameter logic [31:0]      FWORD_MAX     = 32'd858_993_459
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Up_P_Flag,
  input  logic        Up_R_Flag,
  input  logic        Sel_P_Flag,
  input  logic        Sel_R_Flag,
`ifdef DDS_KEY_DOWN_EN
  input  logic        Dn_P_Flag,
  input  logic        Dn_R_Flag,
  output logic [1:0]  Dn_State,
`endif
  output logic [1:0]  Up_State,
  output logic [1:0]  Sel_State,
  output logic [31:0] Fword,
  output logic [1:0]  Wave_Sel,
  output logic        Fword_Update
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_LONG = 2'd2} sel_state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CNT - 1'b1;

  sel_state_t       sel_state;
  logic [CNT_W-1:0] sel_cnt;
  logic             sel_short;
  logic             sel_long;
  logic             up_step;
  logic             dn_step;
  logic [32:0]      up_sum;
  logic [31:0]      step_next;
  logic             step_load;

  assign Sel_State = sel_state;

  key_step_fsm #(.CNT_W(CNT_W), .LONG_CNT(LONG_CNT), .REPEAT_CNT(REPEAT_CNT)) u_up_key (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .P_Flag  (Up_P_Flag),
    .R_Flag  (Up_R_Flag),
    .Step    (up_step),
    .State   (Up_State)
  );

`ifdef DDS_KEY_DOWN_EN
  logic [32:0] dn_floor;

  key_step_fsm #(.CNT_W(CNT_W), .LONG_CNT(LONG_CNT), .REPEAT_CNT(REPEAT_CNT)) u_dn_key (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .P_Flag  (Dn_P_Flag),
    .R_Flag  (Dn_R_Flag),
    .Step    (dn_step),
    .State   (Dn_State)
  );

  // Fword-STEP would drop below MIN exactly when Fword < MIN+STEP (33-bit, no wrap).
  assign dn_floor = {1'b0, FWORD_MIN} + {1'b0, FWORD_STEP};
`else
  assign dn_step = 1'b0;
`endif

  // Mode-key requests: short release cycles the waveform, threshold reloads defaults.
  always_comb begin
    sel_short = 1'b0;
    sel_long  = 1'b0;
    if (sel_state == S_HELD) begin
      sel_short = Sel_R_Flag && (sel_cnt < LONG_LAST);
      sel_long  = !Sel_R_Flag && (sel_cnt == LONG_LAST);
    end
  end

  // Saturated next Fword for a single up or down step; opposing steps cancel.
  always_comb begin
    up_sum    = {1'b0, Fword} + {1'b0, FWORD_STEP};
    step_next = Fword;
    step_load = 1'b0;
    if (up_step && !dn_step) begin
      step_next = (up_sum > {1'b0, FWORD_MAX}) ? FWORD_MAX : up_sum[31:0];
      step_load = (step_next != Fword);
    end
`ifdef DDS_KEY_DOWN_EN
    if (dn_step && !up_step) begin
      step_next = ({1'b0, Fword} < dn_floor) ? FWORD_MIN : (Fword - FWORD_STEP);
      step_load = (step_next != Fword);
    end
`endif
  end

  // Mode-key press state and hold counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sel_state <= S_IDLE;
      sel_cnt   <= '0;
    end else begin
      case (sel_state)
        S_IDLE: begin
          if (Sel_P_Flag) begin
            sel_state <= S_HELD;
            sel_cnt   <= '0;
          end
        end
        S_HELD: begin
          if (Sel_R_Flag) begin
            sel_state <= S_IDLE;
            sel_cnt   <= '0;
          end else if (sel_cnt == LONG_LAST) begin
            sel_state <= S_LONG;
            sel_cnt   <= '0;
          end else begin
            sel_cnt <= sel_cnt + 1'b1;
          end
        end
        S_LONG: begin
          if (Sel_R_Flag) sel_state <= S_IDLE;
        end
        default: begin
          sel_state <= S_IDLE;
          sel_cnt   <= '0;
        end
      endcase
    end
  end

  // Registered outputs; a mode-key reload overrides any same-cycle step.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Fword        <= FWORD_DEFAULT;
      Wave_Sel     <= 2'd0;
      Fword_Update <= 1'b0;
    end else if (sel_long) begin
      Fword        <= FWORD_DEFAULT;
      Wave_Sel     <= 2'd0;
      Fword_Update <= 1'b1;
    end else begin
      Fword_Update <= step_load;
      if (step_load) Fword <= step_next;
      if (sel_short) Wave_Sel <= Wave_Sel + 2'd1;
    end
  end
endmodule

// File: tb/tb_dds_key_ctrl.sv
// Bench for dds_key_ctrl: directed scenarios followed by random key traffic,
// every cycle compared against a press-age based reference model.
module tb_dds_key_ctrl;
  localparam int LONG = 20;
  localparam int REP  = 5;
  localparam int DEF  = 1000;
  localparam int STEP = 100;
  localparam int FMIN = 100;
  localparam int FMAX = 1500;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Up_P_Flag, Up_R_Flag, Sel_P_Flag, Sel_R_Flag;
  logic        Dn_P_Flag, Dn_R_Flag;
  logic [1:0]  Up_State, Sel_State, Dn_State;
  logic [31:0] Fword;
  logic [1:0]  Wave_Sel;
  logic        Fword_Update;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_fword, m_wave, m_pulse;
  bit up_held, sel_held, dn_held;
  int up_age, sel_age, dn_age;

  dds_key_ctrl #(
    .CNT_W(24), .LONG_CNT(24'd20), .REPEAT_CNT(24'd5),
    .FWORD_DEFAULT(32'd1000), .FWORD_STEP(32'd100),
    .FWORD_MIN(32'd100), .FWORD_MAX(32'd1500)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Up_P_Flag    (Up_P_Flag),
    .Up_R_Flag    (Up_R_Flag),
    .Sel_P_Flag   (Sel_P_Flag),
    .Sel_R_Flag   (Sel_R_Flag),
`ifdef DDS_KEY_DOWN_EN
    .Dn_P_Flag    (Dn_P_Flag),
    .Dn_R_Flag    (Dn_R_Flag),
    .Dn_State     (Dn_State),
`endif
    .Up_State     (Up_State),
    .Sel_State    (Sel_State),
    .Fword        (Fword),
    .Wave_Sel     (Wave_Sel),
    .Fword_Update (Fword_Update)
  );

`ifndef DDS_KEY_DOWN_EN
  assign Dn_State = 2'd0;
`endif

  // clock
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_fword = DEF; m_wave = 0; m_pulse = 0;
    up_held = 0; sel_held = 0; dn_held = 0;
    up_age = 0; sel_age = 0; dn_age = 0;
  endfunction

  // Step event for a stepping key given the flags sampled at this edge.
  // age = edges since the press edge; step on short release, at age LONG,
  // and every REP edges after that unless released on that edge.
  function automatic bit key_event(input bit p, input bit r, inout bit held, inout int age);
    bit ev = 0;
    if (!held) begin
      if (p) begin held = 1; age = 0; end
    end else begin
      age++;
      if (r) begin
        ev = (age < LONG);
        held = 0;
      end else if (age >= LONG && ((age - LONG) % REP) == 0) begin
        ev = 1;
      end
    end
    return ev;
  endfunction

  function automatic void model_edge();
    bit up_ev, dn_ev, s_short, s_long;
    int nf;
    up_ev = key_event(Up_P_Flag, Up_R_Flag, up_held, up_age);
    dn_ev = 0;
`ifdef DDS_KEY_DOWN_EN
    dn_ev = key_event(Dn_P_Flag, Dn_R_Flag, dn_held, dn_age);
`endif
    s_short = 0; s_long = 0;
    if (!sel_held) begin
      if (Sel_P_Flag) begin sel_held = 1; sel_age = 0; end
    end else begin
      sel_age++;
      if (Sel_R_Flag) begin
        s_short = (sel_age < LONG);
        sel_held = 0;
      end else if (sel_age == LONG) begin
        s_long = 1;
      end
    end
    m_pulse = 0;
    if (s_long) begin
      m_fword = DEF; m_wave = 0; m_pulse = 1;
    end else begin
      if (s_short) m_wave = (m_wave + 1) % 4;
      nf = m_fword;
      if (up_ev && !dn_ev) nf = (m_fword + STEP > FMAX) ? FMAX : m_fword + STEP;
      if (dn_ev && !up_ev) nf = (m_fword - STEP < FMIN) ? FMIN : m_fword - STEP;
      if (nf != m_fword) begin m_fword = nf; m_pulse = 1; end
    end
  endfunction

  // One clock: drive flags (we sit at a negedge), step model at posedge, check at next negedge.
  task automatic cycle(input bit up_p, input bit up_r, input bit sel_p, input bit sel_r,
                       input bit dn_p = 0, input bit dn_r = 0);
    Up_P_Flag = up_p; Up_R_Flag = up_r; Sel_P_Flag = sel_p; Sel_R_Flag = sel_r;
    Dn_P_Flag = dn_p; Dn_R_Flag = dn_r;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    Up_P_Flag = 0; Up_R_Flag = 0; Sel_P_Flag = 0; Sel_R_Flag = 0;
    Dn_P_Flag = 0; Dn_R_Flag = 0;
    check_val("fword", Fword, m_fword);
    check_val("wave_sel", {30'd0, Wave_Sel}, m_wave);
    check_val("fword_update", {31'd0, Fword_Update}, m_pulse);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_fword"}, Fword, 32'd1000);
    check_val({tag, "_wave"}, {30'd0, Wave_Sel}, 32'd0);
    check_val({tag, "_upd"}, {31'd0, Fword_Update}, 32'd0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    check_reset_vals("reset");
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic short_up();
    cycle(1, 0, 0, 0); idle(9); cycle(0, 1, 0, 0);
  endtask

  task automatic short_sel();
    cycle(0, 0, 1, 0); idle(3); cycle(0, 0, 0, 1);
  endtask

  initial begin
    Reset_n = 1'b1;
    Up_P_Flag = 0; Up_R_Flag = 0; Sel_P_Flag = 0; Sel_R_Flag = 0;
    Dn_P_Flag = 0; Dn_R_Flag = 0;
    model_reset();
    @(negedge Clk);
    do_reset();
    idle(2);

    // short step press: 1000 -> 1100 one cycle after release
    short_up();
    check_val("short_up_fword", Fword, 32'd1100);
    check_val("short_up_pulse", {31'd0, Fword_Update}, 32'd1);
    idle(3);

    // long step press, released 40 cycles after press: climbs to 1500 and saturates
    cycle(1, 0, 0, 0); idle(39); cycle(0, 1, 0, 0);
    check_val("long_up_sat", Fword, 32'd1500);
    idle(3);

    // five short mode presses: wave 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin short_sel(); idle(1); end
    check_val("mode_short_wave", {30'd0, Wave_Sel}, 32'd1);

    // bring to Fword=1300, Wave_Sel=2 then long-press mode key for 30 cycles
    cycle(0, 0, 1, 0); idle(29); cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin short_up(); idle(1); end
    for (int i = 0; i < 2; i++) begin short_sel(); idle(1); end
    check_val("pre_long_fword", Fword, 32'd1300);
    check_val("pre_long_wave", {30'd0, Wave_Sel}, 32'd2);
    cycle(0, 0, 1, 0); idle(29); cycle(0, 0, 0, 1);
    check_val("mode_long_fword", Fword, 32'd1000);
    check_val("mode_long_wave", {30'd0, Wave_Sel}, 32'd0);
    idle(3);

    // reset while the step key is in auto-repeat; later release is ignored
    cycle(1, 0, 0, 0); idle(27);
    do_reset();
    cycle(0, 1, 0, 0);
    check_val("post_reset_rel", Fword, 32'd1000);
    idle(2);
    short_up();
    check_val("post_reset_short", Fword, 32'd1100);
    idle(2);

`ifdef DDS_KEY_DOWN_EN
    // reload to 1000, then down short press -> 900
    cycle(0, 0, 1, 0); idle(21); cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0); idle(9); cycle(0, 0, 0, 0, 0, 1);
    check_val("dn_short", Fword, 32'd900);
    idle(2);
    // coincident up and down short presses cancel
    cycle(1, 0, 0, 0, 1, 0); idle(5); cycle(0, 1, 0, 0, 0, 1);
    check_val("up_dn_cancel", Fword, 32'd900);
    check_val("up_dn_nopulse", {31'd0, Fword_Update}, 32'd0);
    idle(2);
    // long down press saturates at FWORD_MIN
    cycle(0, 0, 0, 0, 1, 0); idle(70); cycle(0, 0, 0, 0, 0, 1);
    check_val("dn_long_sat", Fword, 32'd100);
    idle(2);
`endif

    // random key traffic
    for (int i = 0; i < 4000; i++) begin
      bit up_p, up_r, sel_p, sel_r, dn_p, dn_r;
      up_p  = ($urandom_range(0, 15) == 0);
      up_r  = ($urandom_range(0, 11) == 0);
      sel_p = ($urandom_range(0, 19) == 0);
      sel_r = ($urandom_range(0, 13) == 0);
      dn_p  = ($urandom_range(0, 15) == 0);
      dn_r  = ($urandom_range(0, 11) == 0);
      cycle(up_p, up_r, sel_p, sel_r, dn_p, dn_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
